// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV64 OP/OP-IMM/AUIPC issue stage feeding the ALU through a 2-entry skid buffer
module alu_issue_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7_5,
  input  logic            in_is_imm,
  input  logic            in_use_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic [4:0]      in_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] operando1,
  output logic [XLEN-1:0] operando2,
  output logic [3:0]      operador,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic            ill;
  } entry_t;

  entry_t new_e;
  entry_t out_q, out_d, skid_q, skid_d;
  logic   out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic   accept;
  logic   illegal_w;
  logic [3:0]      op_w;
  logic [XLEN-1:0] a_w, b_w;

  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;

  // Translate before the register so SKID only ever holds ready-to-issue entries.
  always_comb begin
    op_w = 4'b0000;
    unique case (in_funct3)
      3'b000:  op_w = (in_funct7_5 && !in_is_imm) ? 4'b0001 : 4'b0000;
      3'b001:  op_w = 4'b0010;
      3'b010:  op_w = 4'b0011;
      3'b011:  op_w = 4'b0011;
      3'b100:  op_w = 4'b0100;
      3'b101:  op_w = in_funct7_5 ? 4'b0110 : 4'b0101;
      3'b110:  op_w = 4'b0111;
      default: op_w = 4'b1000;
    endcase
    illegal_w = !in_use_pc && in_funct7_5 &&
                (!(in_funct3 == 3'b000 || in_funct3 == 3'b101) ||
                 (in_funct3 == 3'b000 && in_is_imm));
    if (in_use_pc) op_w = 4'b0000;

    a_w = in_use_pc ? in_pc : in_rs1;
    b_w = (in_is_imm || in_use_pc) ? in_imm : in_rs2;
    // Biasing both sign bits turns the ALU's unsigned compare into a signed one.
    if (!in_use_pc && in_funct3 == 3'b010) begin
      a_w[XLEN-1] = ~a_w[XLEN-1];
      b_w[XLEN-1] = ~b_w[XLEN-1];
    end

    new_e     = '0;
    new_e.rd  = in_rd;
    new_e.ill = illegal_w;
    if (!illegal_w) begin
      new_e.op1 = a_w;
      new_e.op2 = b_w;
      new_e.op  = op_w;
    end
  end

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_e;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_e;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign operando1   = out_q.op1;
  assign operando2   = out_q.op2;
  assign operador    = out_q.op;
  assign out_rd      = out_q.rd;
  assign out_illegal = out_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic        in_funct7_5, in_is_imm, in_use_pc;
  logic [63:0] in_rs1, in_rs2, in_imm, in_pc;
  logic [4:0]  in_rd;
  logic        out_valid, out_ready;
  logic [63:0] operando1, operando2;
  logic [3:0]  operador;
  logic [4:0]  out_rd;
  logic        out_illegal;

  typedef struct packed {
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_is_imm(in_is_imm),
    .in_use_pc(in_use_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_pc(in_pc), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .operando1(operando1), .operando2(operando2), .operador(operador),
    .out_rd(out_rd), .out_illegal(out_illegal)
  );

  function automatic exp_t model(input logic [2:0] f3, input logic f7, input logic im,
                                 input logic up, input logic [63:0] r1, input logic [63:0] r2,
                                 input logic [63:0] imm, input logic [63:0] pc, input logic [4:0] rd);
    exp_t e;
    logic bad;
    e = '0;
    e.rd = rd;
    if (up) begin
      e.op1 = pc; e.op2 = imm; e.op = 4'd0;
      return e;
    end
    bad = f7 && ((f3 != 3'd0 && f3 != 3'd5) || (f3 == 3'd0 && im));
    if (bad) begin
      e.ill = 1'b1;
      return e;
    end
    e.op1 = r1;
    e.op2 = im ? imm : r2;
    case (f3)
      3'd0: e.op = (f7 && !im) ? 4'd1 : 4'd0;
      3'd1: e.op = 4'd2;
      3'd2: begin
        e.op = 4'd3;
        e.op1 = e.op1 ^ 64'h8000_0000_0000_0000;
        e.op2 = e.op2 ^ 64'h8000_0000_0000_0000;
      end
      3'd3: e.op = 4'd3;
      3'd4: e.op = 4'd4;
      3'd5: e.op = f7 ? 4'd6 : 4'd5;
      3'd6: e.op = 4'd7;
      default: e.op = 4'd8;
    endcase
    return e;
  endfunction

  // Scoreboard pop and hold-stability check, sampled on the falling edge.
  logic  prev_stall = 1'b0;
  exp_t  held;
  exp_t  obs, exp_e;
  always @(negedge clk) begin
    obs = {operando1, operando2, operador, out_rd, out_illegal};
    if (!rst && prev_stall && out_valid) begin
      checks++;
      assert (obs === held) else begin
        errors++; $error("FAIL hold_stable obs=%h exp=%h", obs, held);
      end
    end
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++; $error("FAIL unexpected_output obs=%h exp=none", obs);
      end else begin
        exp_e = sb.pop_front();
        assert (obs === exp_e) else begin
          errors++; $error("FAIL sb_entry obs=%h exp=%h", obs, exp_e);
        end
      end
    end
    prev_stall = !rst && out_valid && !out_ready;
    held = obs;
  end

  task automatic send(input logic [2:0] f3, input logic f7, input logic im, input logic up,
                      input logic [63:0] r1, input logic [63:0] r2, input logic [63:0] imm,
                      input logic [63:0] pc, input logic [4:0] rd, input bit chk_lat,
                      output int waited, output logic ov_seen);
    bit acc;
    acc = 0; waited = 0; ov_seen = 1'b0;
    in_funct3 = f3; in_funct7_5 = f7; in_is_imm = im; in_use_pc = up;
    in_rs1 = r1; in_rs2 = r2; in_imm = imm; in_pc = pc; in_rd = rd; in_valid = 1'b1;
    while (!acc && waited < 50) begin
      @(negedge clk);
      if (waited == 0) ov_seen = out_valid;
      if (in_ready) begin
        sb.push_back(model(f3, f7, im, up, r1, r2, imm, pc, rd));
        acc = 1;
      end
      @(posedge clk); #1;
      waited++;
    end
    in_valid = 1'b0;
    checks++;
    assert (acc) else begin
      errors++; $error("FAIL send_timeout obs=not_accepted exp=accepted rd=%0d", rd);
    end
    if (chk_lat) begin
      @(negedge clk);
      checks++;
      assert (out_valid === 1'b1 && out_rd === rd) else begin
        errors++; $error("FAIL latency obs=%b/%0d exp=1/%0d", out_valid, out_rd, rd);
      end
      @(posedge clk); #1;
    end
  endtask

  int   w;
  logic ov;
  logic [4:0] tag;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_funct3 = '0; in_funct7_5 = 0; in_is_imm = 0; in_use_pc = 0;
    in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_pc = '0; in_rd = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b0 && out_valid === 1'b0) else begin
      errors++; $error("FAIL reset_hold obs=%b%b exp=00", in_ready, out_valid);
    end
    checks++;
    assert ({operando1, operando2, operador, out_rd, out_illegal} === 138'd0) else begin
      errors++; $error("FAIL reset_zero obs=%h exp=0", {operando1, operando2, operador});
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++; $error("FAIL ready_after_reset obs=%b exp=1", in_ready);
    end
    @(posedge clk); #1;

    // Directed translation cases
    send(3'd0, 0, 0, 0, 64'd10, 64'd3, 64'd0, 64'd0, 5'd1, 1, w, ov);
    send(3'd0, 1, 0, 0, 64'd10, 64'd3, 64'd0, 64'd0, 5'd2, 1, w, ov);
    send(3'd2, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd3, 1, w, ov);
    send(3'd3, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0, 5'd4, 1, w, ov);
    send(3'd0, 0, 1, 1, 64'd7, 64'd9, 64'h2000, 64'h1000, 5'd5, 1, w, ov);
    send(3'd5, 1, 1, 0, 64'h8000_0000_0000_0000, 64'd99, 64'd4, 64'd0, 5'd6, 1, w, ov);
    send(3'd0, 1, 1, 0, 64'd5, 64'd6, 64'd7, 64'd0, 5'd7, 1, w, ov);
    send(3'd4, 1, 0, 0, 64'd5, 64'd6, 64'd7, 64'd0, 5'd8, 1, w, ov);
    send(3'd7, 1, 0, 1, 64'd5, 64'd6, 64'd7, 64'd8, 5'd9, 1, w, ov);
    send(3'd1, 0, 0, 0, 64'd1, 64'd70, 64'd0, 64'd0, 5'd10, 1, w, ov);
    send(3'd6, 0, 1, 0, 64'hF0, 64'd0, 64'h0F, 64'd0, 5'd11, 1, w, ov);
    send(3'd7, 0, 0, 0, 64'hFF, 64'h3C, 64'd0, 64'd0, 5'd12, 1, w, ov);
    send(3'd5, 0, 0, 0, 64'hFF, 64'd2, 64'd0, 64'd0, 5'd13, 1, w, ov);
    repeat (2) @(posedge clk); #1;

    // Backpressure: out_ready low in cycles 3..5
    tag = 5'd1;
    for (int c = 1; c <= 12; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_funct3 = 3'd0; in_funct7_5 = 0; in_is_imm = 0; in_use_pc = 0;
      in_rs1 = 64'(c * 3); in_rs2 = 64'(c); in_rd = tag;
      in_valid = (tag <= 5'd6);
      @(negedge clk);
      checks++;
      assert (in_ready === !(c >= 4 && c <= 6)) else begin
        errors++; $error("FAIL bp_in_ready c=%0d obs=%b exp=%b", c, in_ready, !(c >= 4 && c <= 6));
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(3'd0, 0, 0, 0, in_rs1, in_rs2, 64'd0, 64'd0, tag));
        tag++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL bp_drain obs=%0d exp=0", sb.size());
    end

    // 20 back-to-back with simultaneous accept/consume
    for (int i = 0; i < 20; i++) begin
      send(3'(i % 8), 1'(i % 3 == 0), 1'(i % 2), 0, 64'(i * 17), 64'(i + 100),
           64'(i), 64'd0, 5'(i + 1), 0, w, ov);
      checks++;
      assert (w == 1) else begin
        errors++; $error("FAIL b2b_ready i=%0d obs=%0d exp=1", i, w);
      end
      if (i > 0) begin
        checks++;
        assert (ov === 1'b1) else begin
          errors++; $error("FAIL b2b_valid i=%0d obs=%b exp=1", i, ov);
        end
      end
    end
    @(negedge clk);
    checks++;
    assert (out_valid === 1'b1) else begin
      errors++; $error("FAIL b2b_last_valid obs=%b exp=1", out_valid);
    end
    @(posedge clk); #1;
    repeat (2) @(posedge clk); #1;

    // Reset while FULL
    out_ready = 1'b0;
    send(3'd0, 0, 0, 0, 64'd1, 64'd1, 64'd0, 64'd0, 5'd21, 0, w, ov);
    send(3'd0, 0, 0, 0, 64'd2, 64'd2, 64'd0, 64'd0, 5'd22, 0, w, ov);
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b0 && out_valid === 1'b1) else begin
      errors++; $error("FAIL full_state obs=%b%b exp=01", in_ready, out_valid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    assert (in_ready === 1'b0) else begin
      errors++; $error("FAIL ready_in_rst obs=%b exp=0", in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    checks++;
    assert (out_valid === 1'b0 && in_ready === 1'b1 && out_rd === 5'd0) else begin
      errors++; $error("FAIL post_rst obs=%b%b/%0d exp=01/0", out_valid, in_ready, out_rd);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(3'd4, 0, 0, 0, 64'hAA, 64'h55, 64'd0, 64'd0, 5'd30, 1, w, ov);
    repeat (4) @(posedge clk); #1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL final_drain obs=%0d exp=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
